// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with write bypass and a per-register busy scoreboard
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ctrl_clear,
  input  logic                    ctrl_writeEnable,
  input  logic [ADDR_W-1:0]       ctrl_writeReg,
  input  logic [WIDTH-1:0]        data_writeReg,
  input  logic                    ctrl_reserve,
  input  logic [ADDR_W-1:0]       ctrl_reserveReg,
  input  logic [NREAD*ADDR_W-1:0] ctrl_readReg,
  output logic [NREAD*WIDTH-1:0]  data_readReg,
  output logic [NREAD-1:0]        busy_read,
  output logic                    busy_any
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             write_ok;
  logic             reserve_ok;
  assign write_ok   = ctrl_writeEnable && !(ZERO_REG != 0 && ctrl_writeReg == '0);
  assign reserve_ok = ctrl_reserve && !(ZERO_REG != 0 && ctrl_reserveReg == '0);
  // reserve is applied after the write so a back-to-back producer keeps the register busy
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      busy <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (ctrl_clear) begin
      busy <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (write_ok) begin
        regs[ctrl_writeReg] <= data_writeReg;
        busy[ctrl_writeReg] <= 1'b0;
      end
      if (reserve_ok) busy[ctrl_reserveReg] <= 1'b1;
    end
  assign busy_any = |busy;
  genvar g;
  for (g = 0; g < NREAD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              zero;
    logic              byp;
    assign a    = ctrl_readReg[g*ADDR_W +: ADDR_W];
    // reset forces zeros even while a bypassable write is presented
    assign zero = reset || (ZERO_REG != 0 && a == '0);
    assign byp  = BYPASS != 0 && ctrl_writeEnable && ctrl_writeReg == a;
    assign data_readReg[g*WIDTH +: WIDTH] = zero ? '0 : byp ? data_writeReg : regs[a];
    assign busy_read[g] = zero ? 1'b0 : byp ? (ctrl_reserve && ctrl_reserveReg == a) : busy[a];
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with write bypass and a per-register busy scoreboard, the next-generation replacement for the fixed 32×32, 2-read-port regfile instantiated beside the processor in the skeleton top level. It holds the architectural integer registers, serves NREAD combinational read ports for a pipelined core, and tracks which registers have an outstanding producer so the core can detect RAW hazards without its own tracking logic.

## Interface
- WIDTH, 32, data width of each register
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W
- NREAD, 2, number of read ports (1..8)
- BYPASS, 1, 1: a read of the register being written this cycle returns data_writeReg; 0: returns stored value
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes, and never reports busy

- clock  in  1  master clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all registers and busy bits
- ctrl_clear  in  1  synchronous clear; same effect as reset at the next edge
- ctrl_writeEnable  in  1  write strobe
- ctrl_writeReg  in  ADDR_W  write address
- data_writeReg  in  WIDTH  write data
- ctrl_reserve  in  1  mark a register busy (instruction issued, result pending)
- ctrl_reserveReg  in  ADDR_W  register to mark busy
- ctrl_readReg  in  NREAD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- data_readReg  out  NREAD*WIDTH  read data; port i at bits [i*WIDTH +: WIDTH]
- busy_read  out  NREAD  busy bit of the register addressed by each read port
- busy_any  out  1  OR of all busy bits

## Operation
- Storage: DEPTH×WIDTH flops plus a DEPTH-bit busy vector; no memory macro.
- Write: on the rising edge with ctrl_writeEnable=1, reg[ctrl_writeReg] <= data_writeReg and busy[ctrl_writeReg] <= 0. With ZERO_REG=1, writes to address 0 are discarded.
- Reserve: on the rising edge with ctrl_reserve=1, busy[ctrl_reserveReg] <= 1. With ZERO_REG=1, reserves of address 0 are ignored.
- Same register written and reserved in the same cycle: the reserve wins, so busy ends at 1 and the data is still written. This covers a back-to-back producer.
- Different registers written and reserved in the same cycle: both updates take effect.
- ctrl_clear=1 zeroes all registers and busy bits at the edge. It overrides write and reserve in that cycle.
- Reads are combinational, per port i, address a:
  - If ZERO_REG and a==0: data 0, busy 0.
  - Else if BYPASS and ctrl_writeEnable and ctrl_writeReg==a: data = data_writeReg.
    - busy_read = 1 only if ctrl_reserve and ctrl_reserveReg==a.
    - Otherwise busy_read = 0, because the write retires the producer.
  - Else: data = reg[a], busy_read = busy[a].
- Read ports are fully independent; any ports may address the same register.
- busy_any reflects registered state only, with no bypass.

## Timing
- Reset (async assert) puts every register at 0 and every busy bit at 0. As a result, data_readReg = 0, busy_read = 0 and busy_any = 0 within the same cycle, independent of clock.
- Reset deassertion: the first update happens at the first rising edge while reset is low.
- Write-to-read latency:
  - BYPASS=1: 0 cycles, visible in the same cycle.
  - BYPASS=0: visible after the edge.
- Reserve-to-busy latency is 1 edge; reserve is not bypassed onto busy_read except in the same-address write+reserve case above.
- Reset asserted mid-cycle with a write pending: the write is lost, and the register reads 0.
- No handshakes or stalls; one write and one reserve can be accepted every cycle.

## Test plan
- Reset: preload reg5=0xDEADBEEF with busy[5]=1, then pulse reset asynchronously between edges -> data_readReg port0 (addr 5) = 0, busy_read=0, busy_any=0 immediately, before the next edge.
- Write/read: write reg7=0x12345678, next cycle read port0=7, port1=7 -> both 0x12345678. Write reg0=0xFFFFFFFF -> read reg0 = 0.
- Bypass: BYPASS=1, write reg3=0xA5A5A5A5 while port1 reads 3 in the same cycle -> port1=0xA5A5A5A5 before the edge. With BYPASS=0 -> old value until after the edge.
- Scoreboard: reserve reg9 -> next cycle busy_read[0] (addr 9)=1 and busy_any=1. Write reg9=0x55 -> after the edge busy=0 and data 0x55. Same-cycle write+reserve of reg9 -> busy stays 1 and data updated.
- Clear precedence: with regs 1..4 nonzero, assert ctrl_clear together with write reg2=0x77 and reserve reg4 -> after the edge all reads 0 and busy_any=0.
- Parameter sweep: WIDTH=16, ADDR_W=3, NREAD=4, four ports reading 1,2,3,1 after writes 0x1111, 0x2222, 0x3333 -> outputs 0x1111, 0x2222, 0x3333, 0x1111.
